// File: rtl/cic_dec_ctrl_sync_fifo.sv
// Show-ahead synchronous FIFO with explicit occupancy count; push while full is
// accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Storage is reset too so the read port shows zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/cic_dec_ctrl.sv
// Run-time sequencer for the CIC decimator: start/stop, settling-transient discard,
// and buffering of settled samples onto a valid/ready stream.
module cic_dec_ctrl #(
  parameter int COUT       = 16,
  parameter int SETTLE     = 6,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             cic_dval,
  input  logic [COUT-1:0]  cic_data,
  output logic             cic_enable,
  output logic             cic_clr_n,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [COUT-1:0]  m_data,
  output logic             busy,
  output logic             settled,
  output logic             ovf,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [LW-1:0]    fifo_level
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PRIME = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] FIRST = (SETTLE == 0) ? RUN : PRIME;

  localparam int DW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [DW-1:0] LAST = DW'((SETTLE > 0) ? SETTLE - 1 : 0);

  logic [1:0]    state;
  logic [DW-1:0] disc_cnt;
  logic          go;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;

  assign go   = (state == IDLE) & start & ~stop;
  assign push = (state == RUN) & cic_dval;
  assign pop  = m_valid & m_ready;

  assign cic_enable = (state != IDLE);
  assign cic_clr_n  = (state != IDLE);
  assign busy       = (state != IDLE);
  assign settled    = (state == RUN);
  assign m_valid    = ~fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      disc_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (go) begin
          state    <= FIRST;
          disc_cnt <= '0;
        end
        PRIME: begin
          if (stop) state <= IDLE;
          else if (cic_dval) begin
            // The SETTLE-th strobe is itself discarded; RUN starts with the next one.
            if (disc_cnt == LAST) state <= RUN;
            else                  disc_cnt <= disc_cnt + 1'b1;
          end
        end
        RUN:     if (stop) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf        <= 1'b0;
      sample_cnt <= '0;
    end else if (go) begin
      ovf        <= 1'b0;
      sample_cnt <= '0;
    end else if (push) begin
      if (fifo_full && !pop)  ovf <= 1'b1;
      else if (sample_cnt != '1) sample_cnt <= sample_cnt + 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (COUT),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (cic_data),
    .pop   (pop),
    .dout  (m_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

endmodule

// File: tb/tb_cic_dec_ctrl.sv
// Scenario tasks plus a randomized run against a sample-counting queue model.
module tb_cic_dec_ctrl;

  localparam int COUT       = 16;
  localparam int SETTLE     = 6;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = 16;
  localparam int LW         = $clog2(FIFO_DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             cic_dval = 1'b0;
  logic [COUT-1:0]  cic_data = '0;
  logic             m_ready = 1'b0;
  logic             cic_enable, cic_clr_n, m_valid, busy, settled, ovf;
  logic [COUT-1:0]  m_data;
  logic [CNT_W-1:0] sample_cnt;
  logic [LW-1:0]    fifo_level;

  int errors = 0;
  int checks = 0;

  // Model: "on" plus a count of discarded strobes, and the FIFO as a queue.
  bit              mdl_on;
  int              mdl_disc;
  logic [COUT-1:0] q[$];
  bit              mdl_ovf;
  int              mdl_cnt;

  always #5 clk = ~clk;

  cic_dec_ctrl #(
    .COUT(COUT), .SETTLE(SETTLE), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .cic_dval(cic_dval), .cic_data(cic_data),
    .cic_enable(cic_enable), .cic_clr_n(cic_clr_n),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .busy(busy), .settled(settled), .ovf(ovf),
    .sample_cnt(sample_cnt), .fifo_level(fifo_level)
  );

  task automatic mdl_reset();
    mdl_on = 0; mdl_disc = 0; mdl_ovf = 0; mdl_cnt = 0;
    q.delete();
  endtask

  task automatic tick();
    bit s_start, s_stop, s_dval, s_pop, s_run;
    logic [COUT-1:0] s_data;
    s_start = start; s_stop = stop; s_dval = cic_dval; s_data = cic_data;
    s_pop = (q.size() != 0) && m_ready;
    s_run = mdl_on && (mdl_disc >= SETTLE);
    @(posedge clk); #1;
    if (!rst_n) mdl_reset();
    else begin
      if (s_pop) void'(q.pop_front());
      if (s_run && s_dval) begin
        if (q.size() < FIFO_DEPTH) begin
          q.push_back(s_data);
          if (mdl_cnt < (1 << CNT_W) - 1) mdl_cnt++;
        end else mdl_ovf = 1;
      end
      if (!mdl_on) begin
        if (s_start && !s_stop) begin
          mdl_on = 1; mdl_disc = 0; mdl_ovf = 0; mdl_cnt = 0;
        end
      end else if (s_stop) mdl_on = 0;
      else if (!s_run && s_dval) mdl_disc++;
    end
  endtask

  task automatic run_to_run();
    cic_dval = 0; stop = 1; tick(); stop = 0;
    start = 1; tick(); start = 0;
    cic_dval = 1;
    repeat (SETTLE) begin cic_data = COUT'($urandom); tick(); end
    cic_dval = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; tick(); tick();
    checks++; if ({cic_enable, cic_clr_n, m_valid, busy, settled, ovf} !== 6'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 000000", {cic_enable, cic_clr_n, m_valid, busy, settled, ovf});
    end
    checks++; if (m_data !== '0 || sample_cnt !== '0 || fifo_level !== '0) begin
      errors++; $display("FAIL reset_values: data=%0h cnt=%0d level=%0d expected all 0", m_data, sample_cnt, fifo_level);
    end
    rst_n = 1;
  endtask

  task automatic test_settle();
    logic [COUT-1:0] got[$];
    m_ready = 1;
    start = 1; tick(); start = 0;
    checks++; if (busy !== 1'b1 || cic_clr_n !== 1'b1 || cic_enable !== 1'b1 || settled !== 1'b0) begin
      errors++; $display("FAIL start_prime: busy=%b clr_n=%b en=%b settled=%b expected 1 1 1 0", busy, cic_clr_n, cic_enable, settled);
    end
    for (int i = 1; i <= 10; i++) begin
      cic_dval = 1; cic_data = COUT'(i);
      if (m_valid && m_ready) got.push_back(m_data);
      tick();
      if (i == 5) begin
        checks++; if (settled !== 1'b0) begin errors++; $display("FAIL settle_early: settled=%b expected 0", settled); end
      end
      if (i == 6) begin
        checks++; if (settled !== 1'b1) begin errors++; $display("FAIL settle_rise: settled=%b expected 1", settled); end
      end
    end
    cic_dval = 0;
    repeat (3) begin if (m_valid && m_ready) got.push_back(m_data); tick(); end
    checks++; if (got.size() != 4) begin errors++; $display("FAIL settle_count: got %0d samples expected 4", got.size()); end
    for (int k = 0; k < 4 && k < got.size(); k++) begin
      checks++; if (got[k] !== COUT'(7 + k)) begin errors++; $display("FAIL settle_data[%0d]: got %0h expected %0h", k, got[k], 7 + k); end
    end
    checks++; if (sample_cnt !== CNT_W'(4)) begin errors++; $display("FAIL settle_cnt: got %0d expected 4", sample_cnt); end
  endtask

  task automatic test_overflow();
    m_ready = 0;
    run_to_run();
    for (int i = 0; i < 6; i++) begin
      cic_dval = 1; cic_data = COUT'(16'h10 + i); tick();
      if (i == 3) begin
        checks++; if (fifo_level !== LW'(4) || ovf !== 1'b0) begin errors++; $display("FAIL ovf_fill: level=%0d ovf=%b expected 4 0", fifo_level, ovf); end
      end
      if (i == 4) begin
        checks++; if (fifo_level !== LW'(4) || ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: level=%0d ovf=%b expected 4 1", fifo_level, ovf); end
      end
    end
    cic_dval = 0;
    checks++; if (sample_cnt !== CNT_W'(4)) begin errors++; $display("FAIL ovf_cnt: got %0d expected 4", sample_cnt); end
    m_ready = 1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (m_valid !== 1'b1 || m_data !== COUT'(16'h10 + k)) begin
        errors++; $display("FAIL ovf_drain[%0d]: valid=%b data=%0h expected 1 %0h", k, m_valid, m_data, 16'h10 + k);
      end
      tick();
    end
    checks++; if (m_valid !== 1'b0 || fifo_level !== '0) begin errors++; $display("FAIL ovf_empty: valid=%b level=%0d expected 0 0", m_valid, fifo_level); end
  endtask

  task automatic test_full_pushpop();
    m_ready = 0;
    run_to_run();
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL restart_ovf: got %b expected 0", ovf); end
    for (int i = 0; i < 4; i++) begin cic_dval = 1; cic_data = COUT'(16'h20 + i); tick(); end
    m_ready = 1; cic_data = 16'h24;
    checks++; if (fifo_level !== LW'(4) || m_data !== 16'h20) begin errors++; $display("FAIL full_pre: level=%0d data=%0h expected 4 20", fifo_level, m_data); end
    tick();
    cic_dval = 0; m_ready = 0;
    checks++; if (fifo_level !== LW'(4) || ovf !== 1'b0 || sample_cnt !== CNT_W'(5)) begin
      errors++; $display("FAIL full_pushpop: level=%0d ovf=%b cnt=%0d expected 4 0 5", fifo_level, ovf, sample_cnt);
    end
    m_ready = 1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (m_data !== COUT'(16'h21 + k)) begin errors++; $display("FAIL full_drain[%0d]: got %0h expected %0h", k, m_data, 16'h21 + k); end
      tick();
    end
  endtask

  task automatic test_stop_dval();
    m_ready = 0;
    run_to_run();
    cic_dval = 1; cic_data = 16'h50; tick();
    stop = 1; cic_data = 16'h55; tick();
    stop = 0; cic_dval = 0;
    checks++; if (cic_enable !== 1'b0 || cic_clr_n !== 1'b0 || busy !== 1'b0 || fifo_level !== LW'(2)) begin
      errors++; $display("FAIL stop_dval: en=%b clr_n=%b busy=%b level=%0d expected 0 0 0 2", cic_enable, cic_clr_n, busy, fifo_level);
    end
    m_ready = 1;
    checks++; if (m_data !== 16'h50) begin errors++; $display("FAIL stop_drain0: got %0h expected 50", m_data); end
    tick();
    checks++; if (m_valid !== 1'b1 || m_data !== 16'h55) begin errors++; $display("FAIL stop_drain1: valid=%b data=%0h expected 1 55", m_valid, m_data); end
    tick();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL stop_empty: valid=%b expected 0", m_valid); end
  endtask

  task automatic test_start_stop();
    m_ready = 1;
    start = 1; stop = 1; tick(); start = 0; stop = 0;
    checks++; if (busy !== 1'b0 || cic_enable !== 1'b0) begin errors++; $display("FAIL start_stop_idle: busy=%b en=%b expected 0 0", busy, cic_enable); end
    run_to_run();
    cic_dval = 1; tick(); tick(); cic_dval = 0;
    start = 1; tick(); start = 0;
    checks++; if (settled !== 1'b1 || busy !== 1'b1 || sample_cnt !== CNT_W'(2)) begin
      errors++; $display("FAIL start_in_run: settled=%b busy=%b cnt=%0d expected 1 1 2", settled, busy, sample_cnt);
    end
  endtask

  task automatic test_async_reset();
    m_ready = 0;
    run_to_run();
    cic_dval = 1; tick(); tick(); cic_dval = 0;
    stop = 1; tick(); stop = 0;
    start = 1; tick(); start = 0;
    cic_dval = 1; repeat (3) tick(); cic_dval = 0;
    #2 rst_n = 0; mdl_reset();
    #1;
    checks++; if ({cic_enable, cic_clr_n, m_valid, busy, settled, ovf} !== 6'b0 || fifo_level !== '0 || m_data !== '0 || sample_cnt !== '0) begin
      errors++; $display("FAIL async_reset: flags=%b level=%0d data=%0h cnt=%0d expected all 0",
                         {cic_enable, cic_clr_n, m_valid, busy, settled, ovf}, fifo_level, m_data, sample_cnt);
    end
    #2 rst_n = 1;
    tick();
    start = 1; tick(); start = 0;
    for (int i = 1; i <= 6; i++) begin
      cic_dval = 1; cic_data = COUT'(16'h60 + i); tick();
      if (i == 5) begin
        checks++; if (settled !== 1'b0) begin errors++; $display("FAIL rearm_early: settled=%b expected 0", settled); end
      end
    end
    checks++; if (settled !== 1'b1 || m_valid !== 1'b0) begin errors++; $display("FAIL rearm_settle: settled=%b valid=%b expected 1 0", settled, m_valid); end
    cic_data = 16'h77; tick(); cic_dval = 0;
    checks++; if (m_valid !== 1'b1 || m_data !== 16'h77 || sample_cnt !== CNT_W'(1)) begin
      errors++; $display("FAIL rearm_first: valid=%b data=%0h cnt=%0d expected 1 77 1", m_valid, m_data, sample_cnt);
    end
  endtask

  task automatic test_random();
    bit exp_run;
    for (int n = 0; n < 600; n++) begin
      start    = ($urandom_range(0, 15) == 0);
      stop     = ($urandom_range(0, 39) == 0);
      cic_dval = $urandom_range(0, 1) == 1;
      cic_data = COUT'($urandom);
      m_ready  = ($urandom_range(0, 2) != 0);
      tick();
      exp_run = mdl_on && (mdl_disc >= SETTLE);
      checks++; if ({busy, settled, cic_enable, cic_clr_n} !== {mdl_on, exp_run, mdl_on, mdl_on}) begin
        errors++; $display("FAIL rnd_state@%0d: got %b expected %b", n, {busy, settled, cic_enable, cic_clr_n}, {mdl_on, exp_run, mdl_on, mdl_on});
      end
      checks++; if (fifo_level !== LW'(q.size()) || m_valid !== (q.size() != 0)) begin
        errors++; $display("FAIL rnd_level@%0d: level=%0d valid=%b expected %0d", n, fifo_level, m_valid, q.size());
      end
      if (q.size() != 0) begin
        checks++; if (m_data !== q[0]) begin errors++; $display("FAIL rnd_data@%0d: got %0h expected %0h", n, m_data, q[0]); end
      end
      checks++; if (ovf !== mdl_ovf || sample_cnt !== CNT_W'(mdl_cnt)) begin
        errors++; $display("FAIL rnd_stat@%0d: ovf=%b cnt=%0d expected %b %0d", n, ovf, sample_cnt, mdl_ovf, mdl_cnt);
      end
    end
    start = 0; stop = 0; cic_dval = 0;
  endtask

  initial begin
    mdl_reset();
    test_reset();
    test_settle();
    test_overflow();
    test_full_pushpop();
    test_stop_dval();
    test_start_stop();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cic_dec_ctrl.md
Name: cic_dec_ctrl

Overview:
Run-time sequencer for the CIC decimator. It starts and stops the decimator and holds it cleared while idle. After each start it discards the comb-section settling transient. Settled output samples go into a small FIFO and leave on a valid/ready stream. Sits between the CIC decimator and downstream consumers, and exposes status to the control/register logic.

Parameters:
COUT, 16, width of decimator sample (dout_cut) and of m_data
SETTLE, 6, decimated samples discarded after each start (N*M for the default N=3, M=2); 0 allowed
FIFO_DEPTH, 4, output FIFO entries; power of 2, >=2
CNT_W, 16, width of accepted-sample counter

Ports:
clk  in  1  clock, same as decimator input sample clock
rst_n  in  1  asynchronous reset, active-low
start  in  1  one-cycle start request
stop  in  1  one-cycle stop request
cic_dval  in  1  decimator output-valid strobe
cic_data  in  COUT  decimator dout_cut; valid when cic_dval=1
cic_enable  out  1  drives decimator enable_cic
cic_clr_n  out  1  local clear; integrated as decimator rst_n = rst_n & cic_clr_n
m_valid  out  1  output sample available
m_ready  in  1  consumer accepts sample
m_data  out  COUT  output sample
busy  out  1  state != IDLE
settled  out  1  state == RUN
ovf  out  1  sticky FIFO-overflow flag
sample_cnt  out  CNT_W  samples accepted into FIFO since last start, saturating
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset values: cic_enable=0, cic_clr_n=0, m_valid=0, m_data=0, busy=0, settled=0, ovf=0, sample_cnt=0, fifo_level=0, state=IDLE.
- All outputs are registered or decoded directly from registered state; no combinational path from inputs to outputs except none.
- FSM states: IDLE, PRIME, RUN.
- IDLE:
  - cic_enable=0, cic_clr_n=0, so the decimator is held cleared.
  - start=1 and stop=0: on the next edge, clear ovf, sample_cnt and the discard counter. Go to PRIME, or straight to RUN if SETTLE=0.
  - start and stop together in IDLE: stop wins; stay in IDLE.
- PRIME:
  - cic_enable=1, cic_clr_n=1.
  - Each cic_dval increments the discard counter; the sample is dropped.
  - When the SETTLE-th dval arrives, go to RUN on that edge. That sample is also discarded.
- RUN:
  - cic_enable=1, cic_clr_n=1.
  - Each cic_dval pushes cic_data into the FIFO in the same cycle.
- stop in PRIME or RUN: go to IDLE on the next edge; cic_enable and cic_clr_n fall that edge.
  - A cic_dval in the same cycle as stop, while in RUN, is still pushed.
- start while in PRIME or RUN: ignored.
- FIFO:
  - Show-ahead. A push on edge k gives m_valid=1 and m_data valid immediately after edge k when the FIFO was empty.
  - Pop occurs on m_valid & m_ready.
  - Push and pop in the same cycle: level unchanged, including when full.
  - Push when full with no pop: sample dropped, ovf set, sample_cnt not incremented, FIFO contents unchanged.
  - FIFO content survives stop and keeps draining in IDLE. It is never flushed by start.
- sample_cnt: +1 per accepted push; saturates at 2^CNT_W-1.
- ovf: cleared only by rst_n or an accepted start.
- Pointer wrap: the read/write pointers are $clog2(FIFO_DEPTH) bits wide and wrap naturally. fifo_level is kept explicitly.
- Asynchronous reset mid-operation: return to the reset values immediately. The FIFO empties and the decimator is cleared via cic_clr_n=0.

Decomposition:
- No shared package needed.
- State encoding stays as localparams in the module.
- One sub-module is natural: sync_fifo, parameterised by WIDTH and DEPTH, with push/pop/full/empty/level ports. It is reusable by other decimation paths.

Test Plan:
1. SETTLE=6. Reset, start, then 10 cic_dval pulses with data 1..10, m_ready=1.
   - Expect: busy=1 and cic_clr_n=1 after the start edge.
   - Expect: m_data stream 7,8,9,10; settled rises on the 6th dval edge; sample_cnt=4.
2. FIFO_DEPTH=4, m_ready=0 in RUN. Push 6 samples 0x10..0x15.
   - Expect: fifo_level=4 and ovf=1 after the 5th push; sample_cnt=4.
   - Then m_ready=1: output 0x10..0x13 and m_valid falls.
3. Full FIFO with m_ready=1 and cic_dval on the same cycle.
   - Expect: level stays 4, ovf stays 0, the new sample is appended.
4. stop asserted in the same cycle as cic_dval with data 0x55 in RUN.
   - Expect: 0x55 is delivered; next cycle cic_enable=0, cic_clr_n=0, busy=0.
   - Expect: the remaining FIFO content drains.
5. start and stop together in IDLE: stays IDLE, cic_enable=0.
   - start during RUN: no state change, sample_cnt not cleared.
6. rst_n asserted mid-PRIME after 3 dval.
   - Expect: all outputs return to reset values immediately.
   - After release and start, a fresh 6-sample discard occurs.
